// File: rtl/branch_redirect_ctrl.sv
// PC-update and redirect stage. Owns the architectural fetch PC, picks the
// next PC from a taken EX branch, an ID jump, a stall hold or PC+4, raises
// the same-cycle IF/ID and ID/EX flushes, and keeps saturating branch
// statistics for the debug bus.
module branch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic             taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             jmp_valid_i,
  input  logic [31:0]      jmp_target_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             fetch_valid_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  // BOOT covers the single instruction-memory read-latency cycle after reset.
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_p1;
  logic             vld_p1;
  logic [31:0]      pc_p1;
  logic [CNT_W-1:0] br_cnt_p1;
  logic [CNT_W-1:0] taken_cnt_p1;

  logic             run;
  logic             br_take;
  logic             jmp_take;
  logic [31:0]      pc_seq;
  logic [31:0]      pc_next;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Fetch addresses are word aligned; low target bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign run = (state_p1 == RUN);

  // A taken EX branch beats everything; a jump only redirects when ID is
  // not frozen and is not itself on the wrong path behind that branch.
  assign br_take  = run & br_valid_i & taken_i;
  assign jmp_take = run & jmp_valid_i & ~stall_i & ~br_take;

  // Sequential successor wraps modulo 2^32 with no indication.
  assign pc_seq = pc_p1 + 32'd4;

  // Next-PC selection in priority order: branch, stall hold, jump, PC+4.
  always_comb begin
    pc_next = pc_seq;
    if (!run)          pc_next = pc_p1;
    else if (br_take)  pc_next = align_word(br_target_i);
    else if (stall_i)  pc_next = pc_p1;
    else if (jmp_take) pc_next = align_word(jmp_target_i);
  end

  // Boot sequencer: one BOOT cycle after reset, then RUN with fetch valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p1 <= BOOT;
      vld_p1   <= 1'b0;
    end else begin
      case (state_p1)
        BOOT: begin
          state_p1 <= RUN;
          vld_p1   <= 1'b1;
        end
        RUN: begin
          state_p1 <= RUN;
          vld_p1   <= 1'b1;
        end
        default: begin
          state_p1 <= BOOT;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  // Architectural PC register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_p1 <= RESET_PC;
    else       pc_p1 <= pc_next;
  end

  // Branch statistics: counted in RUN only, regardless of stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_p1    <= '0;
      taken_cnt_p1 <= '0;
    end else begin
      if (run && br_valid_i) br_cnt_p1    <= sat_inc(br_cnt_p1);
      if (br_take)           taken_cnt_p1 <= sat_inc(taken_cnt_p1);
    end
  end

  assign pc_o          = pc_p1;
  assign pc_plus4_o    = pc_seq;
  assign fetch_valid_o = vld_p1;
  // The ID/EX flush also squashes any jump sitting in ID behind the branch.
  assign flush_ifid_o  = br_take | jmp_take;
  assign flush_idex_o  = br_take;
  assign br_cnt_o      = br_cnt_p1;
  assign taken_cnt_o   = taken_cnt_p1;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: three instances share stimulus
// (default, wrap-around reset PC, 2-bit counters); a reference model pushes
// expected outputs per cycle and a negedge monitor pops and compares.
module tb_branch_redirect_ctrl;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_valid_i = 1'b0;
  logic        taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jmp_valid_i = 1'b0;
  logic [31:0] jmp_target_i = '0;

  logic [31:0] pc_w [ND];
  logic [31:0] p4_w [ND];
  logic        fv_w [ND];
  logic        ifid_w [ND];
  logic        idex_w [ND];
  logic [15:0] br0, tk0, br1, tk1;
  logic [1:0]  br2, tk2;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .taken_i(taken_i), .br_target_i(br_target_i), .jmp_valid_i(jmp_valid_i),
    .jmp_target_i(jmp_target_i), .pc_o(pc_w[0]), .pc_plus4_o(p4_w[0]),
    .fetch_valid_o(fv_w[0]), .flush_ifid_o(ifid_w[0]), .flush_idex_o(idex_w[0]),
    .br_cnt_o(br0), .taken_cnt_o(tk0));

  branch_redirect_ctrl #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .taken_i(taken_i), .br_target_i(br_target_i), .jmp_valid_i(jmp_valid_i),
    .jmp_target_i(jmp_target_i), .pc_o(pc_w[1]), .pc_plus4_o(p4_w[1]),
    .fetch_valid_o(fv_w[1]), .flush_ifid_o(ifid_w[1]), .flush_idex_o(idex_w[1]),
    .br_cnt_o(br1), .taken_cnt_o(tk1));

  branch_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .taken_i(taken_i), .br_target_i(br_target_i), .jmp_valid_i(jmp_valid_i),
    .jmp_target_i(jmp_target_i), .pc_o(pc_w[2]), .pc_plus4_o(p4_w[2]),
    .fetch_valid_o(fv_w[2]), .flush_ifid_o(ifid_w[2]), .flush_idex_o(idex_w[2]),
    .br_cnt_o(br2), .taken_cnt_o(tk2));

  logic [15:0] brc_w [ND];
  logic [15:0] tkc_w [ND];
  assign brc_w[0] = br0;
  assign tkc_w[0] = tk0;
  assign brc_w[1] = br1;
  assign tkc_w[1] = tk1;
  assign brc_w[2] = {14'd0, br2};
  assign tkc_w[2] = {14'd0, tk2};

  typedef struct packed {
    logic [ND-1:0][31:0] pc;
    logic [ND-1:0][31:0] p4;
    logic [ND-1:0]       fv;
    logic [ND-1:0]       ifid;
    logic [ND-1:0]       idex;
    logic [ND-1:0][15:0] br;
    logic [ND-1:0][15:0] tk;
  } exp_t;

  exp_t q[$];

  // Reference model state, one entry per instance.
  logic [31:0] rst_pc [ND];
  int unsigned cmax   [ND];
  logic [31:0] m_pc   [ND];
  bit          m_run  [ND];
  int unsigned m_br   [ND];
  int unsigned m_tk   [ND];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_pc[d]  = rst_pc[d];
      m_run[d] = 1'b0;
      m_br[d]  = 0;
      m_tk[d]  = 0;
    end
  endtask

  // Expected outputs for the current cycle given current inputs.
  task automatic push_exp();
    exp_t e;
    bit bt, jt;
    for (int d = 0; d < ND; d++) begin
      bt = m_run[d] && !rst_i && br_valid_i && taken_i;
      jt = m_run[d] && !rst_i && jmp_valid_i && !stall_i && !bt;
      e.pc[d]   = m_pc[d];
      e.p4[d]   = m_pc[d] + 32'd4;
      e.fv[d]   = m_run[d];
      e.ifid[d] = bt || jt;
      e.idex[d] = bt;
      e.br[d]   = 16'(m_br[d]);
      e.tk[d]   = 16'(m_tk[d]);
    end
    q.push_back(e);
  endtask

  // Model state after the coming clock edge.
  task automatic advance();
    bit bt, jt;
    if (rst_i) begin
      model_reset();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      if (!m_run[d]) begin
        m_run[d] = 1'b1;
      end else begin
        bt = br_valid_i && taken_i;
        jt = jmp_valid_i && !stall_i && !bt;
        if (br_valid_i && m_br[d] < cmax[d]) m_br[d]++;
        if (bt && m_tk[d] < cmax[d]) m_tk[d]++;
        if (bt)           m_pc[d] = br_target_i & 32'hFFFF_FFFC;
        else if (stall_i) m_pc[d] = m_pc[d];
        else if (jt)      m_pc[d] = jmp_target_i & 32'hFFFF_FFFC;
        else              m_pc[d] = m_pc[d] + 32'd4;
      end
    end
  endtask

  task automatic step(input bit st, input bit bv, input bit tk, input logic [31:0] bt,
                      input bit jv, input logic [31:0] jt);
    stall_i = st; br_valid_i = bv; taken_i = tk; br_target_i = bt;
    jmp_valid_i = jv; jmp_target_i = jt;
    push_exp();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic rand_step();
    step($urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(1) == 1,
         $urandom, $urandom_range(3) == 0, $urandom);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("pc%0d", d), pc_w[d], e.pc[d]);
          chk($sformatf("pc_plus4_%0d", d), p4_w[d], e.p4[d]);
          chk($sformatf("fetch_valid%0d", d), 32'(fv_w[d]), 32'(e.fv[d]));
          chk($sformatf("flush_ifid%0d", d), 32'(ifid_w[d]), 32'(e.ifid[d]));
          chk($sformatf("flush_idex%0d", d), 32'(idex_w[d]), 32'(e.idex[d]));
          chk($sformatf("br_cnt%0d", d), 32'(brc_w[d]), 32'(e.br[d]));
          chk($sformatf("taken_cnt%0d", d), 32'(tkc_w[d]), 32'(e.tk[d]));
          chk($sformatf("taken_le_br%0d", d), 32'(tkc_w[d] <= brc_w[d]), 32'd1);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_pc[0] = 32'h0000_0000; cmax[0] = 16'hFFFF;
    rst_pc[1] = 32'hFFFF_FFF8; cmax[1] = 16'hFFFF;
    rst_pc[2] = 32'h0000_0000; cmax[2] = 3;
    model_reset();
    #2 rst_i = 1'b1;
    @(posedge clk);
    #1;
    idle();
    idle();
    rst_i = 1'b0;
    // BOOT cycle, then 0x0, 0x4, 0x8, 0xC.
    idle();
    idle(); idle(); idle(); idle();
    chk("seq_pc_0x10", pc_w[0], 32'h10);
    chk("wrap_pc", pc_w[1], 32'h8);
    // Taken branch with unaligned target.
    step(0, 1, 1, 32'h103, 0, 32'h0);
    chk("br_redirect", pc_w[0], 32'h100);
    chk("br_cnt_1", 32'(br0), 32'd1);
    chk("tk_cnt_1", 32'(tk0), 32'd1);
    // Branch beats stall and discards the ID jump.
    step(1, 1, 1, 32'h200, 1, 32'h300);
    chk("br_over_stall_jmp", pc_w[0], 32'h200);
    // Jump held under stall, then taken.
    step(1, 0, 0, 32'h0, 1, 32'h400);
    step(1, 0, 0, 32'h0, 1, 32'h400);
    chk("stall_hold", pc_w[0], 32'h200);
    step(0, 0, 0, 32'h0, 1, 32'h400);
    chk("jmp_after_stall", pc_w[0], 32'h400);
    // Five taken branches: 2-bit counters saturate at 3.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h1000 + 32'(i * 16), 0, 32'h0);
    chk("sat_br_cnt", 32'(br2), 32'd3);
    chk("sat_tk_cnt", 32'(tk2), 32'd3);
    for (int i = 0; i < 400; i++) rand_step();
    // Asynchronous reset in mid-cycle.
    step(0, 1, 1, 32'h0000_5000, 0, 32'h0);
    #2 rst_i = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("async_pc%0d", d), pc_w[d], rst_pc[d]);
      chk($sformatf("async_br%0d", d), 32'(brc_w[d]), 32'd0);
      chk($sformatf("async_tk%0d", d), 32'(tkc_w[d]), 32'd0);
      chk($sformatf("async_fv%0d", d), 32'(fv_w[d]), 32'd0);
    end
    q.delete();
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    idle();
    rst_i = 1'b0;
    for (int i = 0; i < 200; i++) rand_step();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- PC-update and redirect stage sitting directly downstream of the branch-condition unit, which supplies taken_i.
- Owns the architectural PC register and selects the next PC from four sources: EX-stage taken branch, ID-stage jump, hazard stall (hold) and sequential PC+4.
- Generates the same-cycle pipeline flush signals for the IF/ID and ID/EX registers.
- Keeps saturating branch statistics counters for the performance/debug bus.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- stall_i  input  1  load-use stall from the hazard unit; freezes PC and IF/ID.
- br_valid_i  input  1  EX stage holds a conditional branch instruction.
- taken_i  input  1  branch condition result for the EX branch; ignored when br_valid_i=0.
- br_target_i  input  32  EX-stage branch target address.
- jmp_valid_i  input  1  ID stage holds j/jal/jr.
- jmp_target_i  input  32  ID-stage jump target address.
- pc_o  output  32  current fetch PC (registered).
- pc_plus4_o  output  32  pc_o + 4, combinational, modulo 2^32.
- fetch_valid_o  output  1  fetched instruction is valid this cycle.
- flush_ifid_o  output  1  bubble the IF/ID register at the next edge.
- flush_idex_o  output  1  bubble the ID/EX register at the next edge.
- br_cnt_o  output  CNT_W  number of resolved conditional branches.
- taken_cnt_o  output  CNT_W  number of taken conditional branches.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - pc_o=RESET_PC; both counters=0; state=BOOT.
  - fetch_valid_o=0; flush_ifid_o=0; flush_idex_o=0.
- FSM states:
  - BOOT: exactly one cycle after reset deasserts. pc_o holds, fetch_valid_o=0, all inputs ignored, counters do not count. Covers the instruction-memory read latency. Transitions to RUN.
  - RUN: fetch_valid_o=1. Stays in RUN until reset.
- Derived terms (RUN only):
  - br_take = br_valid_i & taken_i.
  - jmp_take = jmp_valid_i & ~stall_i & ~br_take.
- Next-PC priority (RUN), highest first:
  - br_take -> br_target_i. Taken branch overrides stall_i: the EX instruction is older than the stalled ones.
  - stall_i -> hold pc_o.
  - jmp_take -> jmp_target_i.
  - otherwise -> pc_o+4. Wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Target alignment: bits [1:0] of the selected target are forced to 0 before loading pc_o.
- Flush outputs (combinational, RUN only; 0 in BOOT):
  - flush_ifid_o = br_take | jmp_take.
  - flush_idex_o = br_take. This squashes the younger instruction in ID, including any jump in ID.
- Simultaneous br_take and jmp_valid_i: the jump is discarded. It is in the wrong-path ID slot and is flushed.
- Jump during stall: no redirect, no flush. The jump stays in ID because IF/ID is frozen and is taken in the first non-stall cycle.
- Counters (RUN only):
  - br_cnt_o increments on every cycle with br_valid_i=1.
  - taken_cnt_o increments when br_take=1.
  - Both saturate at all-ones; no wrap.
  - Counting is independent of stall_i.
- Latency: the redirected PC appears on pc_o one cycle after br_take or jmp_take is sampled. Flushes are asserted in the resolving cycle.
- Invariants:
  - taken_cnt_o <= br_cnt_o at all times.
  - No X on any output after reset.

Test Plan:
- Reset release, no events -> BOOT cycle with pc_o=0x0 and fetch_valid_o=0; then pc_o = 0x0, 0x4, 0x8, 0xC on successive cycles with fetch_valid_o=1.
- At pc_o=0x10 drive br_valid_i=1, taken_i=1, br_target_i=0x103 -> flush_ifid_o=1 and flush_idex_o=1 that cycle; next pc_o=0x100; br_cnt_o=1, taken_cnt_o=1.
- Same cycle: br_valid_i=1, taken_i=1, br_target_i=0x200, stall_i=1, jmp_valid_i=1, jmp_target_i=0x300 -> next pc_o=0x200; no jump taken.
- jmp_valid_i=1, jmp_target_i=0x400, stall_i=1 for 2 cycles then 0 -> pc_o holds 2 cycles with flush_ifid_o=0; then flush_ifid_o=1 and pc_o=0x400 next; flush_idex_o stays 0.
- RESET_PC=0xFFFF_FFF8, no events -> pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc_plus4_o=0x0 while pc_o=0xFFFF_FFFC.
- CNT_W=2, five taken branches, then assert rst_i asynchronously mid-cycle -> both counters stick at 3; on rst_i, pc_o=RESET_PC and counters=0 immediately without a clock edge.
